// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, the ID-stage readers and the write-back
// register file.
interface wb_regfile_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned RWSEL_W = 2,
    parameter int unsigned COMP_W  = 1,
    parameter int unsigned CNT_W   = 64
);
    logic               wb_valid;
    logic [XLEN-1:0]    pc4;
    logic [RWSEL_W-1:0] RWSel;
    logic [REG_AW-1:0]  RegWr;
    logic               RegWe;
    logic [COMP_W-1:0]  COMPOut;
    logic [XLEN-1:0]    ALUOut;
    logic [XLEN-1:0]    DRAMRd;
    logic [REG_AW-1:0]  rs1_addr;
    logic [REG_AW-1:0]  rs2_addr;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic               fwd_we;
    logic [REG_AW-1:0]  fwd_rd;
    logic [XLEN-1:0]    fwd_data;
    logic [CNT_W-1:0]   instret;
    logic [REG_AW-1:0]  dbg_addr;
    logic [XLEN-1:0]    dbg_data;

    modport slave (
        input  wb_valid, pc4, RWSel, RegWr, RegWe, COMPOut, ALUOut, DRAMRd,
        input  rs1_addr, rs2_addr, dbg_addr,
        output rs1_data, rs2_data, fwd_we, fwd_rd, fwd_data, instret, dbg_data
    );

    modport master (
        output wb_valid, pc4, RWSel, RegWr, RegWe, COMPOut, ALUOut, DRAMRd,
        output rs1_addr, rs2_addr, dbg_addr,
        input  rs1_data, rs2_data, fwd_we, fwd_rd, fwd_data, instret, dbg_data
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects the result, commits it to x1..x31 with write-through read bypass,
// drives the WB forward bus and counts retired instructions.
module wb_regfile #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned RWSEL_W = 2,
    parameter int unsigned COMP_W  = 1,
    parameter int unsigned CNT_W   = 64
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    localparam int NREGS = 1 << REG_AW;

    logic [XLEN-1:0]  regs_q [1:NREGS-1];
    logic [CNT_W-1:0] instret_q;
    logic [XLEN-1:0]  wb_data;
    logic             commit;

    always_comb begin
        wb_data = '0;
        case (bus.RWSel)
            RWSEL_W'(0): wb_data = bus.ALUOut;
            RWSEL_W'(1): wb_data = bus.DRAMRd;
            RWSEL_W'(2): wb_data = bus.pc4;
            RWSEL_W'(3): wb_data = XLEN'(bus.COMPOut);
            default:     wb_data = '0;
        endcase
    end

    // Reset masks the commit so neither the bypass nor the hazard unit sees a dropped write.
    assign commit = bus.wb_valid & bus.RegWe & (bus.RegWr != '0) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[bus.RegWr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (bus.wb_valid) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        bus.rs1_data = '0;
        if (bus.rs1_addr != '0) begin
            bus.rs1_data = (commit && bus.rs1_addr == bus.RegWr) ? wb_data
                                                                 : regs_q[bus.rs1_addr];
        end
    end

    always_comb begin
        bus.rs2_data = '0;
        if (bus.rs2_addr != '0) begin
            bus.rs2_data = (commit && bus.rs2_addr == bus.RegWr) ? wb_data
                                                                 : regs_q[bus.rs2_addr];
        end
    end

    always_comb begin
        bus.dbg_data = '0;
        if (bus.dbg_addr != '0) begin
            bus.dbg_data = regs_q[bus.dbg_addr];
        end
    end

    assign bus.fwd_we   = commit;
    assign bus.fwd_rd   = bus.RegWr;
    assign bus.fwd_data = wb_data;
    assign bus.instret  = instret_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table for write-back select and bypass, hand-written
// sequences for reset interaction and instret wrap (on a 4-bit counter instance).
module tb_wb_regfile;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    wb_regfile_if #(.CNT_W(64)) bus ();
    wb_regfile_if #(.CNT_W(4))  bus4 ();

    wb_regfile #(.CNT_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        we;
        logic [1:0]  rwsel;
        logic [4:0]  rd;
        logic        comp;
        logic [31:0] alu;
        logic [31:0] dram;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  dbg;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_dbg;
        logic        e_we;
        logic [31:0] e_fwd;
        logic [63:0] e_ret;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic we, input logic [1:0] rwsel,
                         input logic [4:0] rd, input logic [31:0] alu);
        bus.wb_valid = valid;
        bus.RegWe    = we;
        bus.RWSel    = rwsel;
        bus.RegWr    = rd;
        bus.ALUOut   = alu;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        //        v     we    sel    rd     cmp   alu            dram          pc4
        //        rs1   rs2   dbg    e_rs1          e_rs2          e_dbg
        //        e_we  e_fwd          e_ret
        vecs[0] = '{1'b1, 1'b1, 2'd0, 5'd5, 1'b1, 32'h11, 32'h22, 32'h104,
                    5'd5, 5'd0, 5'd5, 32'h11, 32'h0, 32'h0,
                    1'b1, 32'h11, 64'd0};
        vecs[1] = '{1'b1, 1'b1, 2'd1, 5'd5, 1'b1, 32'h11, 32'h22, 32'h104,
                    5'd5, 5'd0, 5'd5, 32'h22, 32'h0, 32'h11,
                    1'b1, 32'h22, 64'd1};
        vecs[2] = '{1'b1, 1'b1, 2'd2, 5'd5, 1'b1, 32'h11, 32'h22, 32'h104,
                    5'd5, 5'd0, 5'd5, 32'h104, 32'h0, 32'h22,
                    1'b1, 32'h104, 64'd2};
        vecs[3] = '{1'b1, 1'b1, 2'd3, 5'd5, 1'b1, 32'h11, 32'h22, 32'h104,
                    5'd5, 5'd0, 5'd5, 32'h1, 32'h0, 32'h104,
                    1'b1, 32'h1, 64'd3};
        // Bubble with RegWe set: no bypass, no write, no count.
        vecs[4] = '{1'b0, 1'b1, 2'd0, 5'd5, 1'b1, 32'h11, 32'h22, 32'h104,
                    5'd5, 5'd0, 5'd5, 32'h1, 32'h0, 32'h1,
                    1'b0, 32'h11, 64'd4};
        vecs[5] = '{1'b1, 1'b1, 2'd0, 5'd7, 1'b0, 32'hDEADBEEF, 32'h22, 32'h104,
                    5'd7, 5'd7, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h1,
                    1'b1, 32'hDEADBEEF, 64'd4};
        vecs[6] = '{1'b1, 1'b1, 2'd0, 5'd0, 1'b0, 32'hFFFF, 32'h22, 32'h104,
                    5'd0, 5'd7, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0,
                    1'b0, 32'hFFFF, 64'd5};
        vecs[7] = '{1'b1, 1'b0, 2'd0, 5'd7, 1'b0, 32'h1234, 32'h22, 32'h104,
                    5'd7, 5'd5, 5'd7, 32'hDEADBEEF, 32'h1, 32'hDEADBEEF,
                    1'b0, 32'h1234, 64'd6};
        vecs[8] = '{1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 32'h0, 32'h22, 32'h104,
                    5'd7, 5'd5, 5'd7, 32'hDEADBEEF, 32'h1, 32'hDEADBEEF,
                    1'b0, 32'h0, 64'd7};

        rst = 1'b1;
        drive(1'b1, 1'b1, 2'd0, 5'd3, 32'hAA);
        bus.COMPOut  = 1'b0;
        bus.DRAMRd   = '0;
        bus.pc4      = '0;
        bus.rs1_addr = 5'd3;
        bus.rs2_addr = 5'd3;
        bus.dbg_addr = '0;
        bus4.wb_valid = 1'b0;
        bus4.RegWe    = 1'b0;
        bus4.RWSel    = '0;
        bus4.RegWr    = '0;
        bus4.COMPOut  = '0;
        bus4.ALUOut   = '0;
        bus4.DRAMRd   = '0;
        bus4.pc4      = '0;
        bus4.rs1_addr = '0;
        bus4.rs2_addr = '0;
        bus4.dbg_addr = '0;

        @(negedge clk);
        check("fwd_we_in_reset", 64'(bus.fwd_we), 64'd0);
        check("no_bypass_in_reset", 64'(bus.rs1_data), 64'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'h0);

        for (int a = 0; a < 32; a++) begin
            bus.rs1_addr = 5'(a);
            bus.rs2_addr = 5'(31 - a);
            bus.dbg_addr = 5'(a);
            #1;
            check($sformatf("reset_rs1_x%0d", a), 64'(bus.rs1_data), 64'd0);
            check($sformatf("reset_rs2_x%0d", 31 - a), 64'(bus.rs2_data), 64'd0);
            check($sformatf("reset_dbg_x%0d", a), 64'(bus.dbg_data), 64'd0);
        end
        check("reset_instret", bus.instret, 64'd0);
        check("reset_fwd_we", 64'(bus.fwd_we), 64'd0);
        next_cycle();

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].valid, vecs[i].we, vecs[i].rwsel, vecs[i].rd, vecs[i].alu);
            bus.COMPOut  = vecs[i].comp;
            bus.DRAMRd   = vecs[i].dram;
            bus.pc4      = vecs[i].pc4;
            bus.rs1_addr = vecs[i].rs1;
            bus.rs2_addr = vecs[i].rs2;
            bus.dbg_addr = vecs[i].dbg;
            @(negedge clk);
            check($sformatf("v%0d_rs1", i), 64'(bus.rs1_data), 64'(vecs[i].e_rs1));
            check($sformatf("v%0d_rs2", i), 64'(bus.rs2_data), 64'(vecs[i].e_rs2));
            check($sformatf("v%0d_dbg", i), 64'(bus.dbg_data), 64'(vecs[i].e_dbg));
            check($sformatf("v%0d_fwd_we", i), 64'(bus.fwd_we), 64'(vecs[i].e_we));
            check($sformatf("v%0d_fwd_rd", i), 64'(bus.fwd_rd), 64'(vecs[i].rd));
            check($sformatf("v%0d_fwd_data", i), 64'(bus.fwd_data), 64'(vecs[i].e_fwd));
            check($sformatf("v%0d_instret", i), bus.instret, vecs[i].e_ret);
            next_cycle();
        end

        // Commit x9=0x33, then reset on the edge of a second commit x9=0x55.
        drive(1'b1, 1'b1, 2'd0, 5'd9, 32'h33);
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd9;
        bus.dbg_addr = 5'd7;
        next_cycle();
        check("x9_written", 64'(bus.dbg_data), 64'hDEADBEEF);
        check("instret_before_rst", bus.instret, 64'd8);
        drive(1'b1, 1'b1, 2'd0, 5'd9, 32'h55);
        rst = 1'b1;
        @(negedge clk);
        check("rst_masks_bypass", 64'(bus.rs1_data), 64'h33);
        check("rst_masks_fwd_we", 64'(bus.fwd_we), 64'd0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'h0);
        #1;
        check("rst_wins_x9", 64'(bus.rs1_data), 64'd0);
        check("rst_clears_x7", 64'(bus.dbg_data), 64'd0);
        check("rst_clears_instret", bus.instret, 64'd0);

        bus.wb_valid = 1'b1;
        repeat (10) next_cycle();
        bus.wb_valid = 1'b0;
        check("instret_10", bus.instret, 64'd10);
        bus.wb_valid = 1'b1;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus.wb_valid = 1'b0;
        check("instret_rst_drop", bus.instret, 64'd0);

        bus4.wb_valid = 1'b1;
        repeat (15) next_cycle();
        check("instret4_max", 64'(bus4.instret), 64'd15);
        next_cycle();
        check("instret4_wrap", 64'(bus4.instret), 64'd0);
        next_cycle();
        bus4.wb_valid = 1'b0;
        check("instret4_after_wrap", 64'(bus4.instret), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
